// File: rtl/mem_bus_router.sv
// mem_bus_router: steers the CPU and the debug (HCI) master onto internal RAM
// and the memory-mapped IO window. Bus ownership moves through drain states so
// that no read is in flight across a handover. Read data returns after a fixed
// RD_LAT, with the RAM/IO return mux driven by a registered tag.
module mem_bus_router #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 32,
    parameter int RAM_ADDR_W = 17,
    parameter int IO_SEL_W   = 3,
    parameter int RD_LAT     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    // CPU master
    input  logic                  cpu_req,
    input  logic                  cpu_wr,
    input  logic [ADDR_W-1:0]     cpu_a,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic [DATA_W-1:0]     cpu_rdata,
    output logic                  cpu_rvalid,
    output logic                  cpu_rdy,
    // debug master
    input  logic                  dbg_active,
    input  logic                  dbg_req,
    input  logic                  dbg_wr,
    input  logic [RAM_ADDR_W-1:0] dbg_a,
    input  logic [DATA_W-1:0]     dbg_wdata,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  dbg_gnt,
    // RAM slave
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [RAM_ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    // IO slave
    output logic                  io_en,
    output logic                  io_wr,
    output logic [IO_SEL_W-1:0]   io_sel,
    output logic [DATA_W-1:0]     io_wdata,
    input  logic [DATA_W-1:0]     io_rdata,
    input  logic                  io_full,
    // statistics
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        CPU_OWN      = 2'd0,
        DRAIN_TO_DBG = 2'd1,
        DBG_OWN      = 2'd2,
        DRAIN_TO_CPU = 2'd3
    } own_e;

    own_e state;

    logic io_hit;
    logic io_block;
    logic cpu_own;
    logic dbg_own;
    logic busy;
    logic push;
    logic push_io;

    // read tracking: stage 1 takes the issue, stage RD_LAT is the return slot
    logic [RD_LAT:1] vld_pipe;
    logic [RD_LAT:1] io_pipe;
    logic [RD_LAT:1] dbg_pipe;

    // upper CPU address bits above the IO window decode are not routed anywhere
    logic unused_addr;
    assign unused_addr = &{1'b0, cpu_a[ADDR_W-1:RAM_ADDR_W+1]};

    assign io_hit   = (cpu_a[RAM_ADDR_W -: 2] == 2'b11);
    assign io_block = cpu_req & cpu_wr & io_hit & io_full;

    // reset gates the owner qualifiers so nothing is issued or acknowledged
    // while rst_in is held, even though the state already sits at CPU_OWN
    assign cpu_own = rst_in & (state == CPU_OWN);
    assign dbg_own = rst_in & (state == DBG_OWN);
    assign cpu_rdy = cpu_own & ~io_block;

    assign io_sel   = cpu_a[IO_SEL_W-1:0];
    assign io_wdata = cpu_wdata;

    // slave decode for whichever master currently owns the bus; drains issue nothing
    always_comb begin
        ram_en    = 1'b0;
        ram_wr    = 1'b0;
        ram_a     = cpu_a[RAM_ADDR_W-1:0];
        ram_wdata = cpu_wdata;
        io_en     = 1'b0;
        io_wr     = 1'b0;
        if (cpu_own) begin
            ram_en = cpu_req & ~io_hit;
            ram_wr = cpu_req & ~io_hit & cpu_wr;
            io_en  = cpu_req & io_hit & ~io_block;
            io_wr  = cpu_req & io_hit & ~io_block & cpu_wr;
        end else if (dbg_own) begin
            ram_en    = dbg_req;
            ram_wr    = dbg_req & dbg_wr;
            ram_a     = dbg_a;
            ram_wdata = dbg_wdata;
        end
    end

    assign push    = (ram_en & ~ram_wr) | (io_en & ~io_wr);
    assign push_io = io_en & ~io_wr;

    // the return slot empties this cycle, so only earlier stages hold a drain
    always_comb begin
        busy = 1'b0;
        for (int i = 1; i < RD_LAT; i++) busy = busy | vld_pipe[i];
    end

    assign cpu_rvalid = vld_pipe[RD_LAT] & ~dbg_pipe[RD_LAT];
    assign cpu_rdata  = io_pipe[RD_LAT] ? io_rdata : ram_rdata;
    assign dbg_rdata  = ram_rdata;

    // ownership FSM with registered grant
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state   <= CPU_OWN;
            dbg_gnt <= 1'b0;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (dbg_active) state <= DRAIN_TO_DBG;
                end
                DRAIN_TO_DBG: begin
                    if (!dbg_active) begin
                        state <= DRAIN_TO_CPU;
                    end else if (!busy) begin
                        state   <= DBG_OWN;
                        dbg_gnt <= 1'b1;
                    end
                end
                DBG_OWN: begin
                    if (!dbg_active) begin
                        state   <= DRAIN_TO_CPU;
                        dbg_gnt <= 1'b0;
                    end
                end
                DRAIN_TO_CPU: begin
                    if (dbg_active)  state <= DRAIN_TO_DBG;
                    else if (!busy)  state <= CPU_OWN;
                end
                default: begin
                    state   <= CPU_OWN;
                    dbg_gnt <= 1'b0;
                end
            endcase
        end
    end

    // read-return shift register; reset flushes anything in flight
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_pipe <= '0;
            io_pipe  <= '0;
            dbg_pipe <= '0;
        end else begin
            vld_pipe[1] <= push;
            io_pipe[1]  <= push_io;
            dbg_pipe[1] <= dbg_own;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                io_pipe[i]  <= io_pipe[i-1];
                dbg_pipe[i] <= dbg_pipe[i-1];
            end
        end
    end

    // saturating count of cycles where the CPU asks but is not ready
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stall_cnt <= '0;
        end else if (cpu_req && !cpu_rdy && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_bus_router.sv
// Bench for mem_bus_router: directed vectors, read responses checked by a
// scoreboard monitor, control outputs checked inline at the falling edge.
module tb_mem_bus_router;

    localparam int LAT   = 3;
    localparam int CNT_W = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        cpu_req, cpu_wr;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        cpu_rvalid, cpu_rdy;
    logic        dbg_active, dbg_req, dbg_wr;
    logic [16:0] dbg_a;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        dbg_gnt;
    logic        ram_en, ram_wr;
    logic [16:0] ram_a;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        io_en, io_wr;
    logic [2:0]  io_sel;
    logic [7:0]  io_wdata, io_rdata;
    logic        io_full;
    logic [CNT_W-1:0] stall_cnt;

    mem_bus_router #(
        .DATA_W(8), .ADDR_W(32), .RAM_ADDR_W(17), .IO_SEL_W(3),
        .RD_LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_rdy(cpu_rdy),
        .dbg_active(dbg_active), .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_a(dbg_a),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_gnt(dbg_gnt),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .io_en(io_en), .io_wr(io_wr), .io_sel(io_sel), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_full(io_full),
        .stall_cnt(stall_cnt)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // slave models: fixed-latency read data, 0xEE when the slot held no read
    logic [7:0] rp [LAT];
    logic [7:0] ip [LAT];
    initial for (int i = 0; i < LAT; i++) begin rp[i] = 8'hEE; ip[i] = 8'hEE; end
    always @(posedge clk_in) begin
        rp[0] <= (ram_en && !ram_wr) ? (ram_a[7:0] ^ 8'h5A) : 8'hEE;
        ip[0] <= (io_en && !io_wr) ? (8'hC0 | {5'b0, io_sel}) : 8'hEE;
        for (int i = 1; i < LAT; i++) begin
            rp[i] <= rp[i-1];
            ip[i] <= ip[i-1];
        end
    end
    assign ram_rdata = rp[LAT-1];
    assign io_rdata  = ip[LAT-1];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [7:0] data;
        int         at;
    } exp_t;
    exp_t sb[$];

    // monitor: every CPU read return is matched against the scoreboard
    always @(negedge clk_in) begin
        if (cpu_rvalid) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", {31'b0, cpu_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, e.data});
                chk("rvalid_cycle", cyc, e.at);
            end
        end else if (sb.size() > 0 && sb[0].at < cyc) begin
            chk("rvalid_missing", {31'b0, cpu_rvalid}, 32'h1);
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_wr = 0; cpu_a = '0; cpu_wdata = '0;
        dbg_active = 0; dbg_req = 0; dbg_wr = 0; dbg_a = '0; dbg_wdata = '0;
        io_full = 0;
    endtask

    task automatic do_reset();
        step();
        rst_in = 0;
        sb.delete();
        idle_inputs();
        step();
        step();
        rst_in = 1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [7:0] exp);
        exp_t e;
        cpu_req = 1; cpu_wr = 0; cpu_a = a;
        e.data = exp;
        e.at   = cyc + LAT;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    int k, kd;

    initial begin
        rst_in = 0;
        idle_inputs();
        cpu_req = 1; cpu_a = 32'h10;
        #3;
        chk("rst_rvalid", {31'b0, cpu_rvalid}, 0);
        chk("rst_rdy", {31'b0, cpu_rdy}, 0);
        chk("rst_gnt", {31'b0, dbg_gnt}, 0);
        chk("rst_ram_en", {31'b0, ram_en}, 0);
        chk("rst_io_en", {31'b0, io_en}, 0);
        chk("rst_stall", {28'b0, stall_cnt}, 0);
        cpu_req = 0;
        step(); step();
        rst_in = 1;

        // RAM then IO read back to back; address moves on before data returns
        step(); rd(32'h0001_0010 & 32'h0000_FFFF, 8'h4A);
        step(); rd(32'h0003_0000, 8'hC0);
        step(); cpu_req = 0; cpu_a = 32'h0003_0005;
        step(); step(); cpu_a = 32'h0000_0020;
        repeat (3) step();

        // three reads, debug rises with the third; drain then grant
        step(); rd(32'h1, 8'h5B);
        step(); rd(32'h2, 8'h58);
        step(); rd(32'h3, 8'h59); dbg_active = 1; k = cyc;
        step(); cpu_req = 1; cpu_wr = 0; cpu_a = 32'h4;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk_in);
            chk("drain_gnt", {31'b0, dbg_gnt}, 0);
            chk("drain_ram_en", {31'b0, ram_en}, 0);
            chk("drain_rdy", {31'b0, cpu_rdy}, 0);
            step();
        end
        cpu_req = 0;
        dbg_req = 1; dbg_a = 17'h7;
        @(negedge clk_in);
        chk("gnt_cycle", cyc - k, LAT + 1);
        chk("gnt", {31'b0, dbg_gnt}, 1);
        chk("dbg_ram_en", {31'b0, ram_en}, 1);
        chk("dbg_ram_a", {15'b0, ram_a}, 32'h7);
        kd = cyc;
        step(); dbg_req = 0; dbg_active = 0;
        while (cyc < kd + LAT) step();
        @(negedge clk_in);
        chk("dbg_rdata", {24'b0, dbg_rdata}, 32'h5D);
        chk("drain_cpu_rdy", {31'b0, cpu_rdy}, 0);
        step();
        @(negedge clk_in);
        chk("back_to_cpu_rdy", {31'b0, cpu_rdy}, 1);

        // IO write held off by io_full for five cycles
        do_reset();
        step(); cpu_req = 1; cpu_wr = 1; cpu_a = 32'h0003_0000; cpu_wdata = 8'h41; io_full = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("blk_rdy", {31'b0, cpu_rdy}, 0);
            chk("blk_io_en", {31'b0, io_en}, 0);
            step();
        end
        io_full = 0;
        @(negedge clk_in);
        chk("io_en", {31'b0, io_en}, 1);
        chk("io_wr", {31'b0, io_wr}, 1);
        chk("io_wdata", {24'b0, io_wdata}, 32'h41);
        chk("io_rdy", {31'b0, cpu_rdy}, 1);
        chk("stall5", {28'b0, stall_cnt}, 5);
        step(); cpu_req = 0; cpu_wr = 0;

        // stall counter saturation
        do_reset();
        step(); cpu_req = 1; cpu_wr = 1; cpu_a = 32'h0003_0001; io_full = 1;
        repeat (15) step();
        @(negedge clk_in);
        chk("stall15", {28'b0, stall_cnt}, 15);
        repeat (5) step();
        @(negedge clk_in);
        chk("stall_sat", {28'b0, stall_cnt}, 15);
        io_full = 0;
        step(); cpu_req = 0; cpu_wr = 0;

        // one-cycle debug pulse: both drains pass, no grant, nothing issued
        do_reset();
        step(); dbg_active = 1;
        @(negedge clk_in);
        chk("pulse_own_rdy", {31'b0, cpu_rdy}, 1);
        step(); dbg_active = 0; dbg_req = 1; dbg_a = 17'h9;
        @(negedge clk_in);
        chk("pulse_d2d_rdy", {31'b0, cpu_rdy}, 0);
        chk("pulse_d2d_ram_en", {31'b0, ram_en}, 0);
        chk("pulse_d2d_gnt", {31'b0, dbg_gnt}, 0);
        step();
        @(negedge clk_in);
        chk("pulse_d2c_rdy", {31'b0, cpu_rdy}, 0);
        chk("pulse_d2c_ram_en", {31'b0, ram_en}, 0);
        chk("pulse_d2c_gnt", {31'b0, dbg_gnt}, 0);
        step();
        @(negedge clk_in);
        chk("pulse_back_rdy", {31'b0, cpu_rdy}, 1);
        chk("pulse_back_ram_en", {31'b0, ram_en}, 0);
        chk("pulse_back_gnt", {31'b0, dbg_gnt}, 0);
        dbg_req = 0;

        // reset with reads in flight
        do_reset();
        step(); cpu_req = 1; cpu_wr = 1; cpu_a = 32'h0003_0002; cpu_wdata = 8'h55; io_full = 1;
        step(); step(); io_full = 0;
        step(); cpu_wr = 0; cpu_a = 32'h11;
        step(); cpu_a = 32'h12;
        step(); cpu_a = 32'h13;
        chk("pre_rst_stall", {28'b0, stall_cnt}, 2);
        #2 rst_in = 0;
        #1;
        chk("mid_rst_rvalid", {31'b0, cpu_rvalid}, 0);
        chk("mid_rst_rdy", {31'b0, cpu_rdy}, 0);
        chk("mid_rst_ram_en", {31'b0, ram_en}, 0);
        chk("mid_rst_io_en", {31'b0, io_en}, 0);
        chk("mid_rst_gnt", {31'b0, dbg_gnt}, 0);
        chk("mid_rst_stall", {28'b0, stall_cnt}, 0);
        step(); step();
        cpu_req = 0;
        rst_in = 1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk_in);
            chk("post_rst_rvalid", {31'b0, cpu_rvalid}, 0);
            step();
        end
        chk("post_rst_stall", {28'b0, stall_cnt}, 0);

        repeat (LAT + 2) step();
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
